// File: rtl/ppu_pkg.sv
// Purpose: shared widths, arbiter state encoding and memory rw encoding for the PPU memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ppu_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } arb_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/ppu_starve_ctr.sv
// Purpose: saturating wait counter that tracks how long a pending CPU op has been passed over.
// Latency: count updates one cycle after inc/clr; at_limit is combinational from the count.
// Backpressure: none; inc is ignored once the count reaches limit, clr wins over inc.
// Ports: clk/rst (sync, active-high), inc, clr, limit -> cnt, at_limit.
module ppu_starve_ctr #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         at_limit
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < limit)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == limit);

endmodule

// File: rtl/ppu_mem_arb.sv
// Purpose: arbitrates the single-port PPU memory map between the render fetch engine and the CPU PPUDATA port.
// Latency: render data one cycle after grant; CPU write commits at issue, CPU read returns two cycles after issue.
// Backpressure: render never waits (it is dropped only on a forced CPU slot); CPU holds cpu_busy and ignores new requests.
// Ports: clk, rst (sync, active-high);
//   render:  rnd_req, rnd_addr -> rnd_data, rnd_valid, rnd_drop;
//   cpu:     cpu_req, cpu_rw, cpu_addr, cpu_wdata -> cpu_busy, cpu_rdata, cpu_rvalid;
//   memory:  mem_addr, mem_rw, mem_wdata -> mem_rdata (registered read, 1 cycle).
module ppu_mem_arb
  import ppu_pkg::*;
#(
  parameter int ADDR_W       = ppu_pkg::ADDR_W,
  parameter int DATA_W       = ppu_pkg::DATA_W,
  parameter int STARVE_LIMIT = 341
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rnd_req,
  input  logic [ADDR_W-1:0] rnd_addr,
  output logic [DATA_W-1:0] rnd_data,
  output logic              rnd_valid,
  output logic              rnd_drop,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t        state, state_nxt;
  logic              op_rw;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;

  logic              in_pend;
  logic              force_cpu;
  logic              grant_rnd;
  logic              grant_cpu;
  logic              accept;
  logic [CNT_W-1:0]  wait_cnt;
  logic              wait_at_limit;

  assign in_pend   = (state == PEND);
  // Once the CPU has waited the full limit, the render request loses this one slot.
  assign force_cpu = in_pend && (wait_cnt == LIMIT);
  assign grant_rnd = !rst && rnd_req && !force_cpu;
  assign grant_cpu = !rst && in_pend && !grant_rnd;
  assign rnd_drop  = !rst && rnd_req && force_cpu;

  // RD_DONE is not busy: cpu_busy falls in the same cycle cpu_rvalid pulses,
  // so a new request there is accepted back-to-back.
  assign cpu_busy  = !rst && ((state == PEND) || (state == RD_WAIT));
  assign accept    = cpu_req && !cpu_busy;

  assign rnd_data  = mem_rdata;

  ppu_starve_ctr #(.W(CNT_W)) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (in_pend && !grant_cpu && !wait_at_limit),
    .clr      (!in_pend || grant_cpu),
    .limit    (LIMIT),
    .cnt      (wait_cnt),
    .at_limit (wait_at_limit)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RD_DONE: state_nxt = accept ? PEND : IDLE;
      PEND: begin
        if (grant_cpu) begin
          state_nxt = (op_rw == RW_READ) ? RD_WAIT : IDLE;
        end
      end
      RD_WAIT: state_nxt = RD_DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // With no grant the bus idles on a harmless read of address 0.
  always_comb begin
    mem_addr  = '0;
    mem_rw    = RW_READ;
    mem_wdata = '0;
    if (grant_rnd) begin
      mem_addr = rnd_addr;
    end else if (grant_cpu) begin
      mem_addr  = op_addr;
      mem_rw    = op_rw;
      mem_wdata = op_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_rw      <= RW_READ;
      op_addr    <= '0;
      op_wdata   <= '0;
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      rnd_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      rnd_valid  <= grant_rnd;
      cpu_rvalid <= (state == RD_WAIT);
      if (accept) begin
        op_rw    <= cpu_rw;
        op_addr  <= cpu_addr;
        op_wdata <= cpu_wdata;
      end
      // In RD_WAIT the registered read output belongs to the CPU issue of the previous cycle.
      if (state == RD_WAIT) begin
        cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ppu_mem_arb.sv
module tb_ppu_mem_arb;

  localparam int LIM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rnd_req;
  logic [13:0] rnd_addr;
  logic [7:0]  rnd_data;
  logic        rnd_valid;
  logic        rnd_drop;
  logic        cpu_req;
  logic        cpu_rw;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_busy;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic [13:0] mem_addr;
  logic        mem_rw;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ppu_mem_arb #(.ADDR_W(14), .DATA_W(8), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_data(rnd_data),
    .rnd_valid(rnd_valid), .rnd_drop(rnd_drop),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory map behind the arbiter: single port, registered read.
  logic [7:0] mem [0:16383];
  always @(posedge clk) begin
    if (mem_rw) mem_rdata <= mem[mem_addr];
    else        mem[mem_addr] <= mem_wdata;
  end

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 37 + 11) ^ (a >> 6));
  endfunction

  // Reference model: expected memory contents plus the pending CPU op and its age.
  logic [7:0]  ref_mem [0:16383];
  bit          m_pend;
  bit          m_rw;
  logic [13:0] m_addr;
  logic [7:0]  m_wd;
  int          m_wait;
  int          m_rd_phase;   // 0 none, 1 read in flight, 2 result cycle
  logic [7:0]  m_rd_val;

  bit          d_rst, d_cq, d_crw;
  logic [13:0] d_ra, d_ca;
  logic [7:0]  d_cw;
  bit          g_rnd, g_cpu;

  bit          e_busy, e_drop, e_mem_rw, e_rnd_valid, e_rvalid;
  logic [13:0] e_mem_addr;
  logic [7:0]  e_mem_wdata, e_rnd_data, e_rdata;

  task automatic drive(input bit r, input bit rq, input logic [13:0] ra, input bit cq,
                       input bit crw, input logic [13:0] ca, input logic [7:0] cw);
    bit forced;
    rst = r; rnd_req = rq; rnd_addr = ra;
    cpu_req = cq; cpu_rw = crw; cpu_addr = ca; cpu_wdata = cw;
    d_rst = r; d_ra = ra; d_cq = cq; d_crw = crw; d_ca = ca; d_cw = cw;
    e_busy      = !r && (m_pend || m_rd_phase == 1);
    forced      = !r && m_pend && (m_wait == LIM);
    g_rnd       = !r && rq && !forced;
    g_cpu       = !r && m_pend && !g_rnd;
    e_drop      = !r && rq && forced;
    e_mem_addr  = g_rnd ? ra : (g_cpu ? m_addr : 14'd0);
    e_mem_rw    = g_cpu ? m_rw : 1'b1;
    e_mem_wdata = m_wd;
    #1;
  endtask

  task automatic advance();
    bit accept;
    @(posedge clk);
    accept = !d_rst && d_cq && !e_busy;
    if (d_rst) begin
      m_pend = 0; m_wait = 0; m_rd_phase = 0;
      e_rdata = 8'h00; e_rvalid = 0; e_rnd_valid = 0;
    end else begin
      e_rnd_valid = g_rnd;
      if (g_rnd) e_rnd_data = ref_mem[d_ra];
      if (m_rd_phase == 1) begin
        e_rdata = m_rd_val;
        m_rd_phase = 2;
      end else begin
        m_rd_phase = 0;
      end
      if (g_cpu) begin
        if (m_rw) begin
          m_rd_val = ref_mem[m_addr];
          m_rd_phase = 1;
        end else begin
          ref_mem[m_addr] = m_wd;
        end
        m_pend = 0;
        m_wait = 0;
      end else if (m_pend && m_wait < LIM) begin
        m_wait++;
      end
      if (accept) begin
        m_pend = 1; m_rw = d_crw; m_addr = d_ca; m_wd = d_cw; m_wait = 0;
      end
      e_rvalid = (m_rd_phase == 2);
    end
    #1;
  endtask

  task automatic idle_cycle();
    drive(0, 0, 14'd0, 0, 1, 14'd0, 8'd0);
    advance();
  endtask

  task automatic test_reset();
    drive(1, 1, 14'h0155, 1, 0, 14'h0022, 8'h77);
    n_checks++; if (mem_rw !== 1'b1) begin n_errors++; $display("FAIL rst_mem_rw got %0b want 1", mem_rw); end
    n_checks++; if (mem_addr !== 14'd0) begin n_errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    n_checks++; if (rnd_drop !== 1'b0) begin n_errors++; $display("FAIL rst_drop got %0b want 0", rnd_drop); end
    advance();
    drive(0, 0, 14'd0, 0, 1, 14'd0, 8'd0);
    n_checks++; if (cpu_busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy got %0b want 0", cpu_busy); end
    n_checks++; if (cpu_rvalid !== 1'b0) begin n_errors++; $display("FAIL rst_rvalid got %0b want 0", cpu_rvalid); end
    n_checks++; if (cpu_rdata !== 8'h00) begin n_errors++; $display("FAIL rst_rdata got %h want 00", cpu_rdata); end
    n_checks++; if (rnd_valid !== 1'b0) begin n_errors++; $display("FAIL rst_rnd_valid got %0b want 0", rnd_valid); end
    advance();
  endtask

  task automatic test_write_read();
    drive(0, 0, 14'd0, 1, 0, 14'h2005, 8'hA5);
    advance();
    drive(0, 0, 14'd0, 0, 1, 14'd0, 8'd0);
    n_checks++; if (cpu_busy !== 1'b1) begin n_errors++; $display("FAIL wr_busy got %0b want 1", cpu_busy); end
    n_checks++; if ({mem_rw, mem_addr, mem_wdata} !== {1'b0, 14'h2005, 8'hA5}) begin
      n_errors++; $display("FAIL wr_issue got rw=%0b a=%h d=%h want 0/2005/a5", mem_rw, mem_addr, mem_wdata); end
    advance();
    drive(0, 0, 14'd0, 1, 1, 14'h2005, 8'd0);
    n_checks++; if (cpu_busy !== 1'b0) begin n_errors++; $display("FAIL wr_done_busy got %0b want 0", cpu_busy); end
    advance();
    drive(0, 0, 14'd0, 0, 1, 14'd0, 8'd0);
    n_checks++; if ({mem_rw, mem_addr} !== {1'b1, 14'h2005}) begin
      n_errors++; $display("FAIL rd_issue got rw=%0b a=%h want 1/2005", mem_rw, mem_addr); end
    advance();
    drive(0, 0, 14'd0, 0, 1, 14'd0, 8'd0);
    n_checks++; if ({cpu_busy, cpu_rvalid} !== 2'b10) begin
      n_errors++; $display("FAIL rd_wait got busy=%0b rvalid=%0b want 1/0", cpu_busy, cpu_rvalid); end
    advance();
    drive(0, 0, 14'd0, 0, 1, 14'd0, 8'd0);
    n_checks++; if ({cpu_busy, cpu_rvalid, cpu_rdata} !== {2'b01, 8'hA5}) begin
      n_errors++; $display("FAIL rd_done got busy=%0b rvalid=%0b d=%h want 0/1/a5", cpu_busy, cpu_rvalid, cpu_rdata); end
    advance();
  endtask

  task automatic test_render_block();
    for (int c = 0; c <= 12; c++) begin
      drive(0, c < 10, 14'(c), c == 2, 1, 14'h0010, 8'd0);
      if (c < 10) begin
        n_checks++; if ({mem_addr, rnd_drop} !== {14'(c), 1'b0}) begin
          n_errors++; $display("FAIL blk_rnd c=%0d got a=%h drop=%0b want %h/0", c, mem_addr, rnd_drop, c); end
      end
      if (c >= 1 && c <= 10) begin
        n_checks++; if ({rnd_valid, rnd_data} !== {1'b1, init_val(c - 1)}) begin
          n_errors++; $display("FAIL blk_rdata c=%0d got v=%0b d=%h want 1/%h", c, rnd_valid, rnd_data, init_val(c - 1)); end
      end
      if (c == 10) begin
        n_checks++; if ({mem_rw, mem_addr} !== {1'b1, 14'h0010}) begin
          n_errors++; $display("FAIL blk_issue got rw=%0b a=%h want 1/0010", mem_rw, mem_addr); end
      end
      if (c == 11) begin
        n_checks++; if (cpu_rvalid !== 1'b0) begin n_errors++; $display("FAIL blk_early_rvalid got %0b want 0", cpu_rvalid); end
      end
      if (c == 12) begin
        n_checks++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, init_val(16)}) begin
          n_errors++; $display("FAIL blk_cpu got v=%0b d=%h want 1/%h", cpu_rvalid, cpu_rdata, init_val(16)); end
      end
      advance();
    end
  endtask

  task automatic test_starve();
    for (int c = 0; c <= 12; c++) begin
      drive(0, 1, (c == 11) ? 14'h0123 : 14'(c + 32), c == 0, 0, 14'h0123, 8'h5C);
      if (c == 9) begin
        n_checks++; if (rnd_drop !== 1'b1) begin n_errors++; $display("FAIL stv_drop c=9 got %0b want 1", rnd_drop); end
        n_checks++; if ({mem_rw, mem_addr, mem_wdata} !== {1'b0, 14'h0123, 8'h5C}) begin
          n_errors++; $display("FAIL stv_issue got rw=%0b a=%h d=%h want 0/0123/5c", mem_rw, mem_addr, mem_wdata); end
      end else begin
        n_checks++; if (rnd_drop !== 1'b0) begin n_errors++; $display("FAIL stv_nodrop c=%0d got %0b want 0", c, rnd_drop); end
      end
      if (c == 10) begin
        n_checks++; if ({rnd_valid, cpu_busy} !== 2'b00) begin
          n_errors++; $display("FAIL stv_after got v=%0b busy=%0b want 0/0", rnd_valid, cpu_busy); end
      end
      if (c == 12) begin
        n_checks++; if ({rnd_valid, rnd_data} !== {1'b1, 8'h5C}) begin
          n_errors++; $display("FAIL stv_visible got v=%0b d=%h want 1/5c", rnd_valid, rnd_data); end
      end
      advance();
    end
    idle_cycle();
  endtask

  task automatic test_interleave();
    drive(0, 0, 14'd0, 1, 1, 14'h0300, 8'd0);
    advance();
    drive(0, 0, 14'd0, 0, 1, 14'd0, 8'd0);
    n_checks++; if (mem_addr !== 14'h0300) begin n_errors++; $display("FAIL il_issue got %h want 0300", mem_addr); end
    advance();
    drive(0, 1, 14'h0000, 0, 1, 14'd0, 8'd0);
    n_checks++; if ({mem_rw, mem_addr} !== {1'b1, 14'h0000}) begin
      n_errors++; $display("FAIL il_rnd_grant got rw=%0b a=%h want 1/0000", mem_rw, mem_addr); end
    advance();
    drive(0, 0, 14'd0, 0, 1, 14'd0, 8'd0);
    n_checks++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, init_val(14'h0300)}) begin
      n_errors++; $display("FAIL il_cpu got v=%0b d=%h want 1/%h", cpu_rvalid, cpu_rdata, init_val(14'h0300)); end
    n_checks++; if ({rnd_valid, rnd_data} !== {1'b1, init_val(0)}) begin
      n_errors++; $display("FAIL il_rnd got v=%0b d=%h want 1/%h", rnd_valid, rnd_data, init_val(0)); end
    advance();
  endtask

  task automatic test_busy_ignore();
    drive(0, 1, 14'd1, 1, 0, 14'h0040, 8'h11);
    advance();
    for (int c = 1; c <= 2; c++) begin
      drive(0, 1, 14'd1, 1, 0, 14'h0050, 8'h22);
      n_checks++; if ({cpu_busy, mem_addr} !== {1'b1, 14'd1}) begin
        n_errors++; $display("FAIL ign_wait c=%0d got busy=%0b a=%h want 1/0001", c, cpu_busy, mem_addr); end
      advance();
    end
    drive(0, 0, 14'd0, 0, 1, 14'd0, 8'd0);
    n_checks++; if ({mem_rw, mem_addr, mem_wdata} !== {1'b0, 14'h0040, 8'h11}) begin
      n_errors++; $display("FAIL ign_issue got rw=%0b a=%h d=%h want 0/0040/11", mem_rw, mem_addr, mem_wdata); end
    advance();
    drive(0, 0, 14'd0, 0, 1, 14'd0, 8'd0);
    n_checks++; if ({cpu_busy, mem_rw, mem_addr} !== {2'b01, 14'd0}) begin
      n_errors++; $display("FAIL ign_second got busy=%0b rw=%0b a=%h want 0/1/0000", cpu_busy, mem_rw, mem_addr); end
    advance();
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 14'd0, 1, 1, 14'h0040, 8'd0);
    advance();
    idle_cycle();
    idle_cycle();
    drive(0, 0, 14'd0, 1, 0, 14'h0041, 8'h33);
    n_checks++; if ({cpu_busy, cpu_rvalid, cpu_rdata} !== {2'b01, 8'h11}) begin
      n_errors++; $display("FAIL b2b_rd got busy=%0b v=%0b d=%h want 0/1/11", cpu_busy, cpu_rvalid, cpu_rdata); end
    advance();
    drive(0, 0, 14'd0, 0, 1, 14'd0, 8'd0);
    n_checks++; if ({cpu_busy, mem_rw, mem_addr} !== {2'b10, 14'h0041}) begin
      n_errors++; $display("FAIL b2b_wr got busy=%0b rw=%0b a=%h want 1/0/0041", cpu_busy, mem_rw, mem_addr); end
    advance();
  endtask

  task automatic test_reset_rd_wait();
    drive(0, 0, 14'd0, 1, 1, 14'h2005, 8'd0);
    advance();
    idle_cycle();
    drive(1, 0, 14'd0, 0, 1, 14'd0, 8'd0);
    n_checks++; if ({mem_rw, mem_addr} !== {1'b1, 14'd0}) begin
      n_errors++; $display("FAIL rrw_bus got rw=%0b a=%h want 1/0000", mem_rw, mem_addr); end
    advance();
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 14'd0, 0, 1, 14'd0, 8'd0);
      n_checks++; if ({cpu_rvalid, cpu_busy, cpu_rdata} !== 10'd0) begin
        n_errors++; $display("FAIL rrw_after c=%0d got v=%0b busy=%0b d=%h want 0/0/00", c, cpu_rvalid, cpu_busy, cpu_rdata); end
      advance();
    end
  endtask

  task automatic test_random();
    int pct;
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) pct = $urandom_range(20, 100);
      drive($urandom_range(0, 399) == 0,
            $urandom_range(0, 99) < pct,
            14'($urandom_range(0, 31)),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 1),
            14'($urandom_range(0, 31)),
            8'($urandom));
      n_checks++; if ({mem_rw, mem_addr} !== {e_mem_rw, e_mem_addr}) begin
        n_errors++; $display("FAIL rnd_bus c=%0d got rw=%0b a=%h want %0b/%h", c, mem_rw, mem_addr, e_mem_rw, e_mem_addr); end
      if (!e_mem_rw) begin
        n_checks++; if (mem_wdata !== e_mem_wdata) begin
          n_errors++; $display("FAIL rnd_wdata c=%0d got %h want %h", c, mem_wdata, e_mem_wdata); end
      end
      n_checks++; if ({rnd_drop, cpu_busy} !== {e_drop, e_busy}) begin
        n_errors++; $display("FAIL rnd_ctl c=%0d got drop=%0b busy=%0b want %0b/%0b", c, rnd_drop, cpu_busy, e_drop, e_busy); end
      if (!d_rst) begin
        n_checks++; if ({rnd_valid, cpu_rvalid, cpu_rdata} !== {e_rnd_valid, e_rvalid, e_rdata}) begin
          n_errors++; $display("FAIL rnd_regs c=%0d got rv=%0b cv=%0b cd=%h want %0b/%0b/%h",
                               c, rnd_valid, cpu_rvalid, cpu_rdata, e_rnd_valid, e_rvalid, e_rdata); end
        if (e_rnd_valid) begin
          n_checks++; if (rnd_data !== e_rnd_data) begin
            n_errors++; $display("FAIL rnd_rdata c=%0d got %h want %h", c, rnd_data, e_rnd_data); end
        end
      end
      advance();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i]     = init_val(i);
      ref_mem[i] = init_val(i);
    end
    m_pend = 0; m_rw = 1; m_addr = '0; m_wd = '0; m_wait = 0; m_rd_phase = 0; m_rd_val = '0;
    e_rdata = '0; e_rnd_data = '0; e_rvalid = 0; e_rnd_valid = 0;
    rst = 1; rnd_req = 0; rnd_addr = '0; cpu_req = 0; cpu_rw = 1; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_render_block();
    test_starve();
    test_interleave();
    test_busy_ignore();
    test_back_to_back();
    test_reset_rd_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
